parity_frame_rx: RTL and testbench

- Serial receiver for the 3-bit parity word plus generated parity bit produced by the team's combinational even-parity generator.
- Sits directly downstream of the generator after the link serialiser.
- Deframes a start/data/parity/stop serial frame, recomputes parity and presents the data word with parity-error and framing-error flags.
- Feeds the checker stage with one strobed word per frame.

---
 rtl/parity_frame_rx.sv | 120 ++++++++++++
 tb/tb_parity_frame_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop deframer with parity and framing checks.
// Optional saturating error counter enabled by defining PARITY_FRAME_RX_ERRCNT_EN.
module parity_frame_rx #(
  parameter int DATA_W     = 3,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_acc;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_dataOut;
  logic                r_dataValid;
  logic                r_parityErr;
  logic                r_frameErr;
  logic                r_busy;
  logic [DATA_W:0]     w_shiftCat;
  logic [DATA_W-1:0]   w_shiftNext;

  // New bits enter at the MSB so the first (LSB-first) bit lands at bit 0.
  assign w_shiftCat  = {rx_bit, r_shift};
  assign w_shiftNext = w_shiftCat[DATA_W:1];

`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0] r_errCount;
  assign err_count = r_errCount;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_shift     <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
      r_errCount  <= 8'd0;
`endif
    end else begin
      r_dataValid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (!rx_bit) begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_acc   <= PARITY_ODD;
              r_busy  <= 1'b1;
            end
          end
          DATA: begin
            r_shift <= w_shiftNext;
            r_acc   <= r_acc ^ rx_bit;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= PARITY;
            end
          end
          PARITY: begin
            r_acc   <= r_acc ^ rx_bit;
            r_state <= STOP;
          end
          STOP: begin
            // A zero stop bit is reported, never treated as the next start bit.
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_dataOut   <= r_shift;
            r_parityErr <= r_acc;
            r_frameErr  <= ~rx_bit;
            r_dataValid <= 1'b1;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
            if ((r_acc || !rx_bit) && (r_errCount != 8'hFF)) begin
              r_errCount <= r_errCount + 8'd1;
            end
`endif
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_dataOut;
  assign data_valid = r_dataValid;
  assign parity_err = r_parityErr;
  assign frame_err  = r_frameErr;
  assign busy       = r_busy;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomised and directed bench for parity_frame_rx with a frame-level reference model.
// Also exercises err_count when PARITY_FRAME_RX_ERRCNT_EN is defined.
module tb_parity_frame_rx;

  localparam int DATA_W     = 3;
  localparam bit PARITY_ODD = 1'b0;

  logic              clk;
  logic              rst_n;
  logic              bit_en;
  logic              rx_bit;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0]        err_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Annotations written by the driver alongside each strobe
  logic              tbIsStop    = 1'b0;
  logic              tbBusyAfter = 1'b0;
  logic [DATA_W-1:0] tbData      = '0;
  logic              tbPerr      = 1'b0;
  logic              tbFerr      = 1'b0;

  // Frame-level expectations
  logic [DATA_W-1:0] expData  = '0;
  logic              expValid = 1'b0;
  logic              expPerr  = 1'b0;
  logic              expFerr  = 1'b0;
  logic              expBusy  = 1'b0;
  int                expCnt   = 0;

  parity_frame_rx #(
    .DATA_W    (DATA_W),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .rx_bit    (rx_bit),
    .data_out  (data_out),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Each strobe carries one line bit; between strobes the line wiggles to prove it is ignored.
  task automatic applyStimulus(input logic b, input logic isStop, input logic busyAfter, input int gap);
    bit_en      = 1'b1;
    rx_bit      = b;
    tbIsStop    = isStop;
    tbBusyAfter = busyAfter;
    @(negedge clk);
    bit_en   = 1'b0;
    tbIsStop = 1'b0;
    rx_bit   = 1'($urandom);
    repeat (gap) begin
      @(negedge clk);
      rx_bit = 1'($urandom);
    end
  endtask

  task automatic sendFrame(input logic [DATA_W-1:0] data, input logic pbit, input logic stopBit, input int gap);
    tbData = data;
    tbPerr = ((^data) ^ pbit) != PARITY_ODD;
    tbFerr = ~stopBit;
    applyStimulus(1'b0, 1'b0, 1'b1, gap);
    for (int i = 0; i < DATA_W; i++) applyStimulus(data[i], 1'b0, 1'b1, gap);
    applyStimulus(pbit, 1'b0, 1'b1, gap);
    applyStimulus(stopBit, 1'b1, 1'b0, gap);
  endtask

  // Model update on each rising edge, compare just after it settles.
  always @(posedge clk) begin
    if (!rst_n) begin
      expData  = '0;
      expValid = 1'b0;
      expPerr  = 1'b0;
      expFerr  = 1'b0;
      expBusy  = 1'b0;
      expCnt   = 0;
    end else if (bit_en) begin
      expValid = tbIsStop;
      expBusy  = tbBusyAfter;
      if (tbIsStop) begin
        expData = tbData;
        expPerr = tbPerr;
        expFerr = tbFerr;
        if ((tbPerr || tbFerr) && expCnt < 255) expCnt++;
      end
    end else begin
      expValid = 1'b0;
    end
    #1;
    checkOutput("data_valid", 32'(data_valid), 32'(expValid));
    checkOutput("data_out",   32'(data_out),   32'(expData));
    checkOutput("parity_err", 32'(parity_err), 32'(expPerr));
    checkOutput("frame_err",  32'(frame_err),  32'(expFerr));
    checkOutput("busy",       32'(busy),       32'(expBusy));
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    checkOutput("err_count",  32'(err_count),  32'(expCnt));
`endif
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic              pb;
    logic              sb;
    rst_n  = 1'b0;
    bit_en = 1'b0;
    rx_bit = 1'b1;
    @(negedge clk);

    // Reset held while the strobe toggles on an idle line
    for (int i = 0; i < 4; i++) begin
      bit_en = ~bit_en;
      rx_bit = 1'b1;
      @(negedge clk);
    end
    bit_en = 1'b0;
    checkOutput("reset_valid", 32'(data_valid), 32'd0);
    checkOutput("reset_data",  32'(data_out),   32'd0);
    checkOutput("reset_busy",  32'(busy),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean even-parity frame, data 101
    sendFrame(3'b101, 1'b0, 1'b1, 0);
    checkOutput("f1_valid", 32'(data_valid), 32'd1);
    checkOutput("f1_data",  32'(data_out),   32'h5);
    checkOutput("f1_perr",  32'(parity_err), 32'd0);
    checkOutput("f1_ferr",  32'(frame_err),  32'd0);
    checkOutput("f1_model", 32'(expData),    32'h5);
    @(negedge clk);
    checkOutput("f1_pulse_end", 32'(data_valid), 32'd0);

    // Same frame, parity bit flipped
    sendFrame(3'b101, 1'b1, 1'b1, 0);
    checkOutput("f2_data", 32'(data_out),   32'h5);
    checkOutput("f2_perr", 32'(parity_err), 32'd1);
    checkOutput("f2_ferr", 32'(frame_err),  32'd0);
    checkOutput("f2_model_perr", 32'(expPerr), 32'd1);

    // Data 111, parity 1, stop bit 0
    sendFrame(3'b111, 1'b1, 1'b0, 0);
    checkOutput("f3_data", 32'(data_out),   32'h7);
    checkOutput("f3_perr", 32'(parity_err), 32'd0);
    checkOutput("f3_ferr", 32'(frame_err),  32'd1);
    checkOutput("f3_busy", 32'(busy),       32'd0);

    // Two frames with 3-cycle gaps between strobes
    sendFrame(3'b011, 1'b0, 1'b1, 3);
    sendFrame(3'b100, 1'b1, 1'b1, 3);
    checkOutput("b2b_data", 32'(data_out),   32'h4);
    checkOutput("b2b_perr", 32'(parity_err), 32'd0);
    checkOutput("b2b_busy", 32'(busy),       32'd0);

    // Abort a frame with reset after two data bits, then a clean frame
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy),     32'd0);
    checkOutput("abort_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendFrame(3'b010, 1'b1, 1'b1, 0);
    checkOutput("clean_valid", 32'(data_valid), 32'd1);
    checkOutput("clean_data",  32'(data_out),   32'h2);
    checkOutput("clean_perr",  32'(parity_err), 32'd0);

    // Random frames with random gaps, idle strobes and injected errors
    for (int n = 0; n < 150; n++) begin
      d  = DATA_W'($urandom);
      pb = (^d) ^ PARITY_ODD;
      if ($urandom_range(3) == 0) pb = ~pb;
      sb = ($urandom_range(4) != 0);
      repeat ($urandom_range(2)) applyStimulus(1'b1, 1'b0, 1'b0, $urandom_range(2));
      sendFrame(d, pb, sb, $urandom_range(3));
    end

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    for (int n = 0; n < 300; n++) begin
      d = DATA_W'($urandom);
      sendFrame(d, (^d) ^ PARITY_ODD ^ 1'b1, 1'b1, 0);
    end
    checkOutput("errcnt_sat", 32'(err_count), 32'd255);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
